cc_microsequencer: RTL

- Registered micro-program counter (uPC) for the microprogrammed control unit.
- Successor to the combinational next/jump/decode microaddress mux. Adds a uPC register and a conditional jump, plus a call/return stack, hold/stall, and error flags.
- Sits between the control-store microword fields (select, jump address, condition) and the control-store address input; the IR opcode feeds the decode path.

---
 rtl/cc_microseq_pkg.sv | 21 ++
 rtl/cc_microseq_stack.sv | 62 ++++++
 rtl/cc_microsequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/cc_microseq_pkg.sv
// Shared definitions for the microsequencer: next-address modes and the
// constant bits wrapped around the opcode to form a decode entry point.
package cc_microseq_pkg;

    localparam int DATAWIDTH_BUS_DEFAULT = 11;

    typedef enum logic [2:0] {
        MODE_NEXT   = 3'b000,
        MODE_JUMP   = 3'b001,
        MODE_DECODE = 3'b010,
        MODE_CJUMP  = 3'b011,
        MODE_CALL   = 3'b100,
        MODE_RETURN = 3'b101,
        MODE_HOLD   = 3'b110,
        MODE_RSVD   = 3'b111
    } mode_e;

    localparam logic       DECODE_PREFIX = 1'b1;
    localparam logic [1:0] DECODE_SUFFIX = 2'b00;

endpackage

// File: rtl/cc_microseq_stack.sv
// Return-address LIFO for micro-subroutine calls. The occupancy counter
// doubles as the write pointer, so entries never move once written.
module cc_microseq_stack
    import cc_microseq_pkg::*;
#(
    parameter  int WIDTH = DATAWIDTH_BUS_DEFAULT,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             pushEn,
    input  logic             popEn,
    input  logic [WIDTH-1:0] pushData,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] depth,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] stackMem [DEPTH];
    logic [CNT_W-1:0] depthReg;
    logic [CNT_W-1:0] topPos;
    logic [IDX_W-1:0] wrIdx;
    logic [IDX_W-1:0] rdIdx;
    logic             doPush;
    logic             doPop;

    assign full   = (depthReg == CNT_W'(DEPTH));
    assign empty  = (depthReg == '0);
    assign doPush = pushEn && !full;
    assign doPop  = popEn && !empty;
    assign topPos = depthReg - 1'b1;
    assign wrIdx  = depthReg[IDX_W-1:0];
    assign rdIdx  = topPos[IDX_W-1:0];

    // Entries carry no reset: occupancy alone decides what is valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (doPush && (wrIdx == IDX_W'(gi))) begin
                    stackMem[gi] <= pushData;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            depthReg <= '0;
        end else if (doPush && !doPop) begin
            depthReg <= depthReg + 1'b1;
        end else if (doPop && !doPush) begin
            depthReg <= depthReg - 1'b1;
        end
    end

    assign top   = stackMem[rdIdx];
    assign depth = depthReg;

endmodule

// File: rtl/cc_microsequencer.sv
// Registered micro-program counter with jump, decode, conditional jump,
// call/return through a small LIFO, hold/stall, and sticky stack-error flags.
module cc_microsequencer
    import cc_microseq_pkg::*;
#(
    parameter int DATAWIDTH_BUS           = DATAWIDTH_BUS_DEFAULT,
    parameter int DATAWIDTH_DECODE        = 8,
    parameter int DATAWIDTH_MUX_SELECTION = 3,
    parameter int STACK_DEPTH             = 4,
    parameter logic [DATAWIDTH_BUS-1:0] RESET_ADDR = '0
) (
    input  logic                                 CC_MICROSEQ_CLOCK_50,
    input  logic                                 CC_MICROSEQ_RESET_InHigh,
    input  logic                                 CC_MICROSEQ_Stall_In,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0]   CC_MICROSEQ_selection_InBUS,
    input  logic [DATAWIDTH_BUS-1:0]             CC_MICROSEQ_Jump_InBUS,
    input  logic [DATAWIDTH_DECODE-1:0]          CC_MICROSEQ_Decode_InBUS,
    input  logic                                 CC_MICROSEQ_Cond_In,
    output logic [DATAWIDTH_BUS-1:0]             CC_MICROSEQ_data_OutBUS,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     CC_MICROSEQ_Depth_OutBUS,
    output logic                                 CC_MICROSEQ_Overflow_Out,
    output logic                                 CC_MICROSEQ_Underflow_Out
);

    logic [DATAWIDTH_BUS-1:0] upcReg;
    logic [DATAWIDTH_BUS-1:0] upcNext;
    logic [DATAWIDTH_BUS-1:0] incAddr;
    logic [DATAWIDTH_BUS-1:0] stackTop;
    logic                     overflowReg;
    logic                     overflowNext;
    logic                     underflowReg;
    logic                     underflowNext;
    logic                     pushEn;
    logic                     popEn;
    logic                     stackFull;
    logic                     stackEmpty;
    mode_e                    mode;

    assign mode    = mode_e'(CC_MICROSEQ_selection_InBUS);
    assign incAddr = upcReg + 1'b1;

    always_comb begin
        upcNext       = incAddr;
        overflowNext  = overflowReg;
        underflowNext = underflowReg;
        pushEn        = 1'b0;
        popEn         = 1'b0;
        case (mode)
            MODE_NEXT:   upcNext = incAddr;
            MODE_JUMP:   upcNext = CC_MICROSEQ_Jump_InBUS;
            MODE_DECODE: upcNext = {DECODE_PREFIX, CC_MICROSEQ_Decode_InBUS, DECODE_SUFFIX};
            MODE_CJUMP:  upcNext = CC_MICROSEQ_Cond_In ? CC_MICROSEQ_Jump_InBUS : incAddr;
            MODE_CALL: begin
                if (stackFull) begin
                    overflowNext = 1'b1;
                end else begin
                    pushEn  = 1'b1;
                    upcNext = CC_MICROSEQ_Jump_InBUS;
                end
            end
            MODE_RETURN: begin
                if (stackEmpty) begin
                    underflowNext = 1'b1;
                end else begin
                    popEn   = 1'b1;
                    upcNext = stackTop;
                end
            end
            MODE_HOLD:   upcNext = upcReg;
            default:     upcNext = incAddr;
        endcase
    end

    // Stall gates the stack here; reset priority is enforced inside the stack.
    cc_microseq_stack #(
        .WIDTH (DATAWIDTH_BUS),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk      (CC_MICROSEQ_CLOCK_50),
        .srst     (CC_MICROSEQ_RESET_InHigh),
        .pushEn   (pushEn && !CC_MICROSEQ_Stall_In),
        .popEn    (popEn && !CC_MICROSEQ_Stall_In),
        .pushData (incAddr),
        .top      (stackTop),
        .depth    (CC_MICROSEQ_Depth_OutBUS),
        .full     (stackFull),
        .empty    (stackEmpty)
    );

    always_ff @(posedge CC_MICROSEQ_CLOCK_50) begin
        if (CC_MICROSEQ_RESET_InHigh) begin
            upcReg       <= RESET_ADDR;
            overflowReg  <= 1'b0;
            underflowReg <= 1'b0;
        end else if (!CC_MICROSEQ_Stall_In) begin
            upcReg       <= upcNext;
            overflowReg  <= overflowNext;
            underflowReg <= underflowNext;
        end
    end

    assign CC_MICROSEQ_data_OutBUS   = upcReg;
    assign CC_MICROSEQ_Overflow_Out  = overflowReg;
    assign CC_MICROSEQ_Underflow_Out = underflowReg;

endmodule
